// File: rtl/pipe_ctrl.sv
// Pipeline control for the five-stage core: stall/flush generation, exception,
// interrupt and ERET sequencing, and the PC redirect that follows them.
module pipe_ctrl #(
    parameter int ADDR_W  = 30,
    parameter int EXP_W   = 3,
    parameter int EXP_INT = 1,
    parameter int VECTOR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_busy,
    input  logic              mem_busy,
    input  logic              ld_hazard,
    input  logic              irq,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_en_,
    input  logic [1:0]        ex_ctrl_op,
    input  logic [EXP_W-1:0]  ex_exp_code,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic              int_detect,
    output logic              pc_load,
    output logic [ADDR_W-1:0] new_pc,
    output logic              ie,
    output logic [ADDR_W-1:0] epc,
    output logic [EXP_W-1:0]  exp_code
);
    localparam logic [EXP_W-1:0]  EXP_INT_C = EXP_W'(EXP_INT);
    localparam logic [ADDR_W-1:0] VECTOR_C  = ADDR_W'(VECTOR);

    typedef enum logic {RUN, REDIR} state_t;

    state_t             state_q, state_d;
    logic               ie_q, ie_d;
    logic               ie_saved_q, ie_saved_d;
    logic [ADDR_W-1:0]  epc_q, epc_d;
    logic [ADDR_W-1:0]  target_q, target_d;
    logic [EXP_W-1:0]   exp_code_q, exp_code_d;

    logic busy, valid, in_run;
    logic ev_exc, ev_intr, ev_eret, ev_ie_set, ev_ie_clr;

    // Events are only recognised in RUN; the EX/MEM slot is a bubble during REDIR.
    assign busy      = if_busy | mem_busy;
    assign valid     = ~ex_en_ & ~busy;
    assign in_run    = (state_q == RUN);
    assign ev_exc    = in_run & valid & (ex_exp_code != '0);
    assign ev_intr   = in_run & valid & irq & ie_q & ~ev_exc;
    assign ev_eret   = in_run & valid & (ex_ctrl_op == 2'd3) & ~ev_exc & ~ev_intr;
    assign ev_ie_set = in_run & valid & (ex_ctrl_op == 2'd1) & ~ev_exc & ~ev_intr;
    assign ev_ie_clr = in_run & valid & (ex_ctrl_op == 2'd2) & ~ev_exc & ~ev_intr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            ie_q       <= 1'b0;
            ie_saved_q <= 1'b0;
            epc_q      <= '0;
            target_q   <= '0;
            exp_code_q <= '0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            ie_saved_q <= ie_saved_d;
            epc_q      <= epc_d;
            target_q   <= target_d;
            exp_code_q <= exp_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ie_d       = ie_q;
        ie_saved_d = ie_saved_q;
        epc_d      = epc_q;
        target_d   = target_q;
        exp_code_d = exp_code_q;
        if (!busy) begin
            if (state_q == REDIR) begin
                state_d = RUN;
            end else if (ev_exc || ev_intr) begin
                state_d    = REDIR;
                epc_d      = ex_pc;
                ie_saved_d = ie_q;
                ie_d       = 1'b0;
                target_d   = VECTOR_C;
                exp_code_d = ev_exc ? ex_exp_code : EXP_INT_C;
            end else if (ev_eret) begin
                state_d  = REDIR;
                ie_d     = ie_saved_q;
                target_d = epc_q;
            end else if (ev_ie_set) begin
                ie_d = 1'b1;
            end else if (ev_ie_clr) begin
                ie_d = 1'b0;
            end
        end
    end

    always_comb begin
        if_stall   = 1'b0;
        id_stall   = 1'b0;
        ex_stall   = 1'b0;
        mem_stall  = 1'b0;
        if_flush   = 1'b0;
        id_flush   = 1'b0;
        ex_flush   = 1'b0;
        mem_flush  = 1'b0;
        int_detect = ev_intr;
        // The redirect request is held for as long as REDIR lasts, busy or not.
        pc_load    = (state_q == REDIR);
        new_pc     = (state_q == REDIR) ? target_q : '0;
        if (busy) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
        end else if (state_q == REDIR) begin
            if_flush = 1'b1;
        end else if (ev_exc || ev_intr) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
        end else if (ev_eret) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
        end else if (ld_hazard) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
            id_flush = 1'b1;
        end
    end

    assign ie       = ie_q;
    assign epc      = epc_q;
    assign exp_code = exp_code_q;
endmodule
